// File: rtl/bp_serial_link_pkg.sv
// Shared types for the serial link arbiter: FSM state encoding and header beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } bp_serial_link_state_e;

  // Header beat layout: the source id sits right-justified, every bit above it is zero.
  localparam int hdr_id_lsb_gp = 0;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin picker: first requester at or after the pointer wins, wrapping.
// Latency: grant is combinational; the pointer moves on the edge where yumi_i is high.
// Backpressure: grants only while grants_en_i is high; the pointer holds until yumi_i.
module bsg_arb_round_robin #(
  parameter int width_p = 2,
  localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    grants_en_i,
  input  logic [width_p-1:0]      reqs_i,
  input  logic                    yumi_i,
  output logic [width_p-1:0]      grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o
);

  logic [tag_width_lp-1:0] ptr_q, ptr_d;
  logic [width_p-1:0]      reqs_rot;
  logic                    found;
  int                      off;
  int                      sum;

  // Rotate requests so the pointer position lands on bit 0, then take the lowest set bit.
  always_comb begin
    reqs_rot = (reqs_i >> ptr_q) | (reqs_i << (width_p - int'(ptr_q)));
    found    = 1'b0;
    off      = 0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (reqs_rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(ptr_q) + off;
    if (sum >= width_p) sum = sum - width_p;
    tag_o    = tag_width_lp'(sum);
    v_o      = found & grants_en_i;
    grants_o = v_o ? (width_p'(1) << tag_o) : '0;
  end

  // The pointer advances to just past the winner once its word is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i) begin
      ptr_d = (tag_o == tag_width_lp'(width_p - 1)) ? '0 : tag_o + tag_width_lp'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_serial_link_arbiter.sv
// Serialises one round-robin-chosen requester word as a header beat (source id) plus LSB-first slices.
// Latency: word captured at edge t shows its header in cycle t+1; a packet is els_lp+1 beats.
// Backpressure: a beat holds while yumi_i is low; ready_o stays 0 until the last beat is taken.
module bp_serial_link_arbiter
  import bp_serial_link_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int in_width_p  = 64,
  parameter int out_width_p = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_req_p-1:0]            v_i,
  input  logic [num_req_p*in_width_p-1:0] data_i,
  output logic [num_req_p-1:0]            ready_o,
  output logic                            v_o,
  output logic [out_width_p-1:0]          data_o,
  input  logic                            yumi_i
);

  localparam int els_lp       = in_width_p / out_width_p;
  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1;

  bp_serial_link_state_e                    state_q;
  logic [els_lp-1:0][out_width_p-1:0]       buf_q;
  logic [id_width_lp-1:0]                   id_q;
  logic [cnt_width_lp-1:0]                  cnt_q;
  logic [num_req_p-1:0][in_width_p-1:0]     words;
  logic [id_width_lp-1:0]                   win_id;
  logic                                     grants_en;
  logic                                     capture;

  assign words = data_i;

  // Grant only from IDLE, and never while reset is held so ready_o drops with reset.
  assign grants_en = (state_q == IDLE) & ~reset_i;

  bsg_arb_round_robin #(
    .width_p (num_req_p)
  ) arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i (grants_en),
    .reqs_i      (v_i),
    .yumi_i      (capture),
    .grants_o    (ready_o),
    .tag_o       (win_id),
    .v_o         (capture)
  );

  // Packet sequencer: capture in IDLE, then header, then els_lp data slices.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (capture) begin
          buf_q   <= words[win_id];
          id_q    <= win_id;
          state_q <= HDR;
        end
        HDR: if (yumi_i) begin
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (yumi_i) begin
          if (cnt_q == cnt_width_lp'(els_lp - 1)) state_q <= IDLE;
          else                                   cnt_q   <= cnt_q + cnt_width_lp'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat mux: header carries the zero-extended id, data beats walk the captured word LSB first.
  always_comb begin
    v_o    = 1'b0;
    data_o = '0;
    case (state_q)
      HDR: begin
        v_o    = 1'b1;
        data_o = out_width_p'(id_q) << hdr_id_lsb_gp;
      end
      DATA: begin
        v_o    = 1'b1;
        data_o = buf_q[cnt_q];
      end
      default: ;
    endcase
  end

  // A consumer may only take a beat that is being offered.
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted without v_o");

endmodule

// File: tb/tb_bp_serial_link_arbiter.sv
module tb_bp_serial_link_arbiter;

  localparam int N   = 2;
  localparam int IW  = 64;
  localparam int OW  = 16;
  localparam int ELS = IW / OW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    v_i;
  logic [N*IW-1:0] data_i;
  logic [N-1:0]    ready_o;
  logic            v_o;
  logic [OW-1:0]   data_o;
  logic            yumi_i;

  logic            d_v_i;
  logic [31:0]     d_data_i;
  logic            d_ready_o;
  logic            d_v_o;
  logic [15:0]     d_data_o;
  logic            d_yumi_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_serial_link_arbiter #(.num_req_p(N), .in_width_p(IW), .out_width_p(OW)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  bp_serial_link_arbiter #(.num_req_p(1), .in_width_p(32), .out_width_p(16)) dut1 (
    .clk_i(clk), .reset_i(rst), .v_i(d_v_i), .data_i(d_data_i),
    .ready_o(d_ready_o), .v_o(d_v_o), .data_o(d_data_o), .yumi_i(d_yumi_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Packet-level model: a queue of the beats still owed, plus the round-robin pointer.
  logic [OW-1:0] mq[$];
  int            m_ptr = 0;

  always @(negedge clk) begin : model
    int            w;
    logic [N-1:0]  e_rdy;
    logic          e_v;
    logic [OW-1:0] e_d;
    e_rdy = '0; e_v = 1'b0; e_d = '0; w = -1;
    if (rst) begin
      mq.delete();
      m_ptr = 0;
    end else if (mq.size() == 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && v_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) e_rdy[w] = 1'b1;
    end else begin
      e_v = 1'b1;
      e_d = mq[0];
    end
    chk("m_ready", 64'(ready_o), 64'(e_rdy));
    chk("m_v_o",   64'(v_o),     64'(e_v));
    chk("m_data_o",64'(data_o),  64'(e_d));
    if (!rst) begin
      if (w >= 0) begin
        mq.push_back(OW'(w));
        for (int e = 0; e < ELS; e++) mq.push_back(data_i[w*IW + e*OW +: OW]);
        m_ptr = (w + 1) % N;
      end else if (e_v && yumi_i) begin
        void'(mq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    v_i    = '0;
    yumi_i = v_o;
    k = 0;
    while (v_o && k < 60) begin
      tick();
      yumi_i = v_o;
      k++;
    end
    chk("drain_idle", 64'(v_o), 64'(0));
  endtask

  logic [15:0] exp1 [5] = '{16'h0001, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] exp3 [6] = '{16'hAAAA, 16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hCCCC, 16'hDDDD};
  logic        yp3  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] exp6 [3] = '{16'h0000, 16'hCAFE, 16'hBEEF};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hdr_cnt;
    int hdr_cyc [4];
    logic [OW-1:0] hdr_val [4];
    logic prev_v;
    int n;

    rst = 1'b1; v_i = '0; data_i = '0; yumi_i = 1'b0;
    d_v_i = 1'b0; d_data_i = '0; d_yumi_i = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(ready_o), 64'(0));
    chk("rst_v_o",   64'(v_o),     64'(0));
    chk("rst_data",  64'(data_o),  64'(0));
    chk("rst_d_v_o", 64'(d_v_o),   64'(0));

    // Single request from requester 1, yumi follows v_o.
    rst = 1'b0;
    v_i = 2'b10;
    data_i = {64'h4444_3333_2222_1111, 64'h0123_4567_89AB_CDEF};
    #1;
    chk("t1_ready", 64'(ready_o), 64'(2'b10));
    tick();
    v_i = '0; yumi_i = v_o;
    #1;
    chk("t1_ready_busy", 64'(ready_o), 64'(0));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); yumi_i = v_o; #1; end
      chk("t1_v_o",  64'(v_o),    64'(1));
      chk("t1_beat", 64'(data_o), 64'(exp1[i]));
    end
    tick(); yumi_i = v_o; #1;
    chk("t1_gap_v_o", 64'(v_o), 64'(0));

    // Both requesters held: headers alternate with a 6-cycle period.
    v_i = 2'b11;
    hdr_cnt = 0; prev_v = v_o;
    for (int c = 1; c <= 60 && hdr_cnt < 4; c++) begin
      data_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
      yumi_i = v_o;
      if (v_o && !prev_v) begin
        hdr_cyc[hdr_cnt] = c;
        hdr_val[hdr_cnt] = data_o;
        hdr_cnt++;
      end
      prev_v = v_o;
    end
    chk("t2_hdr_count", 64'(hdr_cnt), 64'(4));
    if (hdr_cnt == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_hdr_id", 64'(hdr_val[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk("t2_period", 64'(hdr_cyc[i] - hdr_cyc[i-1]), 64'(ELS + 2));
    end
    drain();

    // Backpressure during DATA holds the current slice.
    v_i = 2'b01;
    data_i = {64'h0, 64'hDDDD_CCCC_BBBB_AAAA};
    yumi_i = 1'b0;
    tick();
    v_i = '0; yumi_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      yumi_i = yp3[i];
      #1;
      chk("t3_v_o",  64'(v_o),    64'(1));
      chk("t3_beat", 64'(data_o), 64'(exp3[i]));
    end
    tick(); yumi_i = v_o; #1;
    chk("t3_end_v_o", 64'(v_o), 64'(0));

    // Reset mid-packet after two data beats; pointer must restart at 0.
    v_i = 2'b01;
    data_i = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222};
    tick(); yumi_i = v_o;
    tick(); yumi_i = v_o;
    tick(); yumi_i = v_o;
    tick();
    chk("t4_pre_v_o", 64'(v_o), 64'(1));
    #1;
    rst = 1'b1; yumi_i = 1'b0;
    #1;
    chk("t4_async_v_o",   64'(v_o),     64'(0));
    chk("t4_async_ready", 64'(ready_o), 64'(0));
    chk("t4_async_data",  64'(data_o),  64'(0));
    tick(); tick();
    rst = 1'b0;
    v_i = 2'b11;
    #1;
    chk("t4_ptr_reset", 64'(ready_o), 64'(2'b01));
    tick(); yumi_i = v_o; v_i = '0; #1;
    chk("t4_fresh_hdr", 64'(data_o), 64'(0));
    chk("t4_fresh_v_o", 64'(v_o),    64'(1));
    drain();

    // Late arrival: requester 1 waits until the IDLE cycle after requester 0's last beat.
    v_i = 2'b01;
    data_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("t5_grant0", 64'(ready_o), 64'(2'b01));
    tick();
    v_i = 2'b11; yumi_i = v_o;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ready_o == 2'b10) break;
      chk("t5_hold", 64'(ready_o[1]), 64'(0));
      tick();
      yumi_i = v_o;
      n++;
    end
    chk("t5_wait", 64'(n), 64'(ELS + 1));
    chk("t5_grant1", 64'(ready_o), 64'(2'b10));
    tick(); yumi_i = v_o;
    drain();

    // Randomised traffic checked every cycle by the model.
    for (int c = 0; c < 400; c++) begin
      v_i    = N'($urandom);
      data_i = {$urandom, $urandom, $urandom, $urandom};
      yumi_i = v_o & 1'($urandom);
      tick();
    end
    drain();

    // Single-requester instance: 32-bit word, two 16-bit slices.
    d_v_i = 1'b1;
    d_data_i = 32'hBEEF_CAFE;
    #1;
    chk("t6_ready", 64'(d_ready_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      d_v_i = 1'b0; d_yumi_i = d_v_o;
      #1;
      chk("t6_v_o",  64'(d_v_o),    64'(1));
      chk("t6_beat", 64'(d_data_o), 64'(exp6[i]));
    end
    tick(); d_yumi_i = d_v_o; #1;
    chk("t6_end_v_o", 64'(d_v_o), 64'(0));

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_serial_link_arbiter.md
# bp_serial_link_arbiter

Shares one narrow serial link between `num_req_p` parallel requesters. Each cycle in which the link is idle, a round-robin winner's `in_width_p` word is captured. The word is then emitted as one header beat carrying the source id, followed by `in_width_p/out_width_p` data beats, LSB slice first. The block sits between several test-harness channels and a single `out_width_p` serial port, and sequences what would otherwise need one PISO converter per channel.

## Interface
- `num_req_p`, 2: number of requesters, at least 1.
- `in_width_p`, 64: requester word width. Must satisfy `in_width_p % out_width_p == 0` and `in_width_p > out_width_p`.
- `out_width_p`, 16: serial beat width. Must be at least `id_width_lp`.
- Derived: `els_lp = in_width_p/out_width_p`; `id_width_lp = max(1, $clog2(num_req_p))`.

Ports:
- `clk_i`  in  1  sole clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  `num_req_p`  per-requester valid.
- `data_i`  in  `num_req_p*in_width_p`  requester words; requester k occupies slice k.
- `ready_o`  out  `num_req_p`  per-requester ready_and. One-hot or zero.
- `v_o`  out  1  serial beat valid.
- `data_o`  out  `out_width_p`  serial beat.
- `yumi_i`  in  1  consumer takes the beat. Legal only while `v_o=1`.

## Operation
States: `IDLE`, `HDR`, `DATA`.

**IDLE**
- `v_o=0`, `data_o=0`.
- If any `v_i` is set, the round-robin winner w is the first set bit at or after `rr_ptr`, wrapping.
- Outputs `ready_o[w]=1`, all other `ready_o` bits 0.
- At the clock edge: `data_i[w]` goes into `buf_r`, w into `id_r`, `rr_ptr <= (w+1) mod num_req_p`, next state `HDR`.
- If no `v_i` is set: `ready_o=0`, stay in `IDLE`, `rr_ptr` unchanged.

**HDR**
- `v_o=1`, `data_o = id_r` zero-extended. `ready_o=0`.
- On `yumi_i`: `cnt_r <= 0`, go to `DATA`.

**DATA**
- `v_o=1`, `data_o = buf_r[cnt_r*out_width_p +: out_width_p]`. `ready_o=0`.
- On `yumi_i`: if `cnt_r == els_lp-1`, go to `IDLE`; otherwise `cnt_r++`.

Rules:
- `cnt_r` is `$clog2(els_lp)` bits wide, minimum 1. It never wraps; exit at `els_lp-1` is explicit.
- Grant is locked from capture until the last data beat is taken. Requests arriving mid-packet wait; `ready_o` stays 0 outside `IDLE`.
- With `num_req_p=1`: `id_r` is 1 bit and always 0, and `rr_ptr` stays 0.

## Timing
- Reset (async assert): state `IDLE`, `rr_ptr=0`, `cnt_r=0`, `buf_r=0`, `id_r=0`. Consequently `v_o=0`, `ready_o=0`, `data_o=0`.
- Reset mid-packet abandons the partial packet; no further beats of it are emitted. Deassert is synchronous to `clk_i` in the harness.
- `ready_o` is combinational from `v_i` and state, with no dependency on `yumi_i`. A requester must not make `v_i` depend on `ready_o`.
- Latency: word accepted at edge t gives header `v_o=1` in cycle t+1.
- With `yumi_i` held high, a packet occupies `els_lp+1` consecutive `v_o` cycles.
- The next capture happens in the `IDLE` cycle after the final beat. Minimum per-word period is `els_lp+2` cycles.
- `data_o` is stable while `v_o=1` and `yumi_i=0` (backpressure holds the beat).
- Simultaneous requests are resolved by `rr_ptr` only. A requester that drops `v_i` before being granted loses nothing; there is no stored request state.
- Assertion: `yumi_i & ~v_o` is an error.

## Structure
- Shared package `bp_serial_link_pkg` holds:
  - `bp_serial_link_state_e`, a 2-bit enum: `IDLE=0`, `HDR=1`, `DATA=2`.
  - Header-format helper constants: header beat = id in the LSBs, zeros above.
- One sub-module: `bsg_arb_round_robin`, used for winner selection and pointer update. Its grant is enabled only in `IDLE`, and its yumi is driven on capture.
- Datapath: one `in_width_p` capture register and a slice mux. No FIFO.

## Test plan
1. **Single request, no backpressure.** Config 2 requesters, 64→16. Requester 1 presents `64'h4444_3333_2222_1111`, `yumi_i=1` throughout. Expect `ready_o=2'b10` for one cycle, then `data_o` = `0001`, `1111`, `2222`, `3333`, `4444` on consecutive cycles, then `v_o=0` for one cycle.
2. **Round-robin fairness.** Both requesters hold `v_i` continuously. Expect headers 0,1,0,1 and a period of 6 cycles per word.
3. **Backpressure.** `yumi_i` toggles 1,0,0,1 during `DATA`. Expect `data_o` to hold the current slice while `yumi_i=0`, with no slice skipped or repeated.
4. **Reset mid-packet.** Assert `reset_i` asynchronously after the second data beat. Expect `v_o=0` and `ready_o=0` immediately, before the next edge. After release, a new request yields a fresh header with `rr_ptr` starting from 0.
5. **Late arrival while busy.** Requester 0 is granted, and requester 1 raises `v_i` during `HDR`. Expect `ready_o[1]` to stay 0 until the `IDLE` cycle following requester 0's last beat, then be granted.
6. **Degenerate config.** `num_req_p=1`, 32→16. Expect header `16'h0000` followed by 2 data beats.
